// File: rtl/fifo_rr_scheduler_pkg.sv
// rtl/fifo_rr_scheduler_pkg.sv - state encoding, default sizes and width helpers for the scheduler
package fifo_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SEND  = 2'd3
  } sched_state_e;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PKT_LEN = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits, even for a count of 1.
  function automatic int idx_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// rtl/fifo_rr_scheduler_if.sv - FIFO-side and link-side signals of the scheduler
interface fifo_rr_scheduler_if
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int SRC_W = idx_w(N_PORTS);

  logic [N_PORTS-1:0]        fifo_empty;
  logic [N_PORTS*DATA_W-1:0] fifo_data;
  logic [N_PORTS-1:0]        fifo_rd_en;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SRC_W-1:0]          out_src;
  logic                      out_sop;
  logic                      out_eop;
  logic                      busy;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_src, out_sop, out_eop, busy
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_src, out_sop, out_eop, busy
  );

endinterface

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rtl/fifo_rr_scheduler_rr_pick.sv - combinational round-robin selector: first request at or after ptr
module rr_pick
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int N = DEF_N_PORTS
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [idx_w(N)-1:0] gnt_idx,
  output logic                any_req
);
  localparam int IW = idx_w(N);
  localparam logic [IW:0] N_L = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic           found;

  // Doubling the request vector turns the rotate into a plain window select.
  always_comb begin
    dbl   = {req, req};
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      rot[i] = dbl[int'(ptr) + i];
    end
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    gnt_idx = sum[IW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - packet-level round-robin drain of N byte FIFOs onto one output link
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = DEF_PKT_LEN
) (
  input logic                 clk,
  input logic                 rst,
  fifo_rr_scheduler_if.master bus
);
  localparam int SRC_W  = idx_w(N_PORTS);
  localparam int BEAT_W = idx_w(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [SRC_W-1:0]  LAST_PORT = SRC_W'(N_PORTS - 1);

  sched_state_e      state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [N_PORTS-1:0] req;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_data;
  logic [N_PORTS-1:0] rd_en;

  assign req      = ~bus.fifo_empty;
  assign sel_data = bus.fifo_data[int'(out_src_q)*DATA_W +: DATA_W];

  rr_pick #(.N(N_PORTS)) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          out_src_d = pick_idx;
          state_d   = ST_ISSUE;
        end
      end
      // Grant is held through starvation; the packet must stay contiguous.
      ST_ISSUE: begin
        if (!bus.fifo_empty[out_src_q]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            rr_ptr_d = (out_src_q == LAST_PORT) ? '0 : out_src_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
    end
  end

  // Never reads an empty FIFO, and never looks at out_ready.
  always_comb begin
    rd_en = '0;
    if (rst && state_q == ST_ISSUE && !bus.fifo_empty[out_src_q]) rd_en[out_src_q] = 1'b1;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_sop    = out_valid_q && (beat_q == '0);
  assign bus.out_eop    = out_valid_q && (beat_q == LAST_BEAT);
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - randomized and directed bench for fifo_rr_scheduler with a packet-level model
module tb_fifo_rr_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_scheduler_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  fifo_rr_scheduler #(.N_PORTS(N), .DATA_W(DW), .PKT_LEN(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Source FIFOs: read data registered one clock after rd_en.
  logic [DW-1:0] mem [N][256];
  int            wr_cnt [N] = '{default: 0};
  int            rd_cnt [N] = '{default: 0};
  logic [DW-1:0] dout   [N] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.fifo_rd_en[i]) begin
        dout[i]   <= mem[i][8'(rd_cnt[i])];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    bus.fifo_empty = '0;
    bus.fifo_data  = '0;
    for (int i = 0; i < N; i++) begin
      bus.fifo_empty[i]         = (wr_cnt[i] == rd_cnt[i]);
      bus.fifo_data[i*DW +: DW] = dout[i];
    end
  end

  // Model state: per-port byte queues plus packet progress.
  typedef struct {
    logic [7:0] data;
    int         src;
    bit         sop;
    bit         eop;
    int         cyc;
  } beat_t;

  beat_t      log_q [$];
  logic [7:0] mq [N][$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         m_active, m_need, m_load, m_show;
  int         m_port, m_sent, m_ptr;
  logic [7:0] m_byte;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    mem[p][8'(wr_cnt[p])] = b;
    wr_cnt[p] = wr_cnt[p] + 1;
    mq[p].push_back(b);
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model: grant at the first idle edge, fetch once the port has data, show a clock later.
  always begin : monitor
    logic [N-1:0] exp_rd;
    int p;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      m_active = 0; m_need = 0; m_load = 0; m_show = 0; m_sent = 0; m_ptr = 0;
    end else if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!m_active && mq[p].size() > 0) begin
          m_active = 1; m_port = p; m_sent = 0; m_need = 1;
        end
      end
    end else if (m_need) begin
      if (mq[m_port].size() > 0) begin
        m_byte = mq[m_port].pop_front();
        m_need = 0;
        m_load = 1;
      end
    end else if (m_load) begin
      m_load = 0;
      m_show = 1;
    end else if (m_show && bus.out_ready) begin
      log_q.push_back('{m_byte, m_port, m_sent == 0, m_sent == PL - 1, cyc});
      m_show = 0;
      m_sent++;
      if (m_sent == PL) begin
        m_active = 0;
        m_ptr = (m_port + 1) % N;
      end else begin
        m_need = 1;
      end
    end
    exp_rd = '0;
    if (rst && m_active && m_need && mq[m_port].size() > 0) exp_rd[m_port] = 1'b1;
    check("busy", 32'(bus.busy), 32'(m_active));
    check("out_valid", 32'(bus.out_valid), 32'(m_show));
    check("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    check("out_sop", 32'(bus.out_sop), 32'(m_show && m_sent == 0));
    check("out_eop", 32'(bus.out_eop), 32'(m_show && m_sent == PL - 1));
    if (m_active) check("out_src", 32'(bus.out_src), 32'(m_port));
    if (m_show) check("out_data", 32'(bus.out_data), 32'(m_byte));
  end

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((m_active || any_pending()) && n < max) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(m_active || any_pending()), 32'd0);
  endtask

  task automatic wait_second_beat(input string name);
    int n;
    n = 0;
    while (!(log_q.size() >= 1 && m_show) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_beat_timeout"}, 32'(log_q.size() >= 1 && m_show), 32'd1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    rst = 1'b0;

    // Reset with traffic pending, then first grant from port 0.
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      push(0, 8'(8'h00 + b));
      push(3, 8'(8'h30 + b));
    end
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
    end
    log_q.delete();
    rst = 1'b1;
    wait_idle("t1", 200);
    check("t1_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      check("t1_first_src", 32'(log_q[0].src), 32'd0);
      check("t1_first_data", 32'(log_q[0].data), 32'h00);
      check("t1_second_src", 32'(log_q[4].src), 32'd3);
      check("t1_second_data", 32'(log_q[4].data), 32'h30);
    end

    // All ports loaded with two packets each: strict 0,1,2,3 rotation.
    log_q.delete();
    @(negedge clk);
    for (int j = 0; j < 2; j++)
      for (int p = 0; p < N; p++)
        for (int b = 0; b < PL; b++) push(p, 8'((p << 4) | (j * 4 + b)));
    wait_idle("t3", 600);
    check("t3_count", 32'(log_q.size()), 32'd32);
    if (log_q.size() == 32) begin
      for (int k = 0; k < 32; k++) begin
        check("t3_src", 32'(log_q[k].src), 32'((k / 4) % 4));
        check("t3_data", 32'(log_q[k].data), 32'((((k / 4) % 4) << 4) | (((k / 4) / 4) * 4 + k % 4)));
      end
    end

    // Single port: A1..A4 on port 2, three clocks apart.
    log_q.delete();
    @(negedge clk);
    for (int b = 0; b < 4; b++) push(2, 8'(8'hA1 + b));
    wait_idle("t2", 100);
    check("t2_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t2_data", 32'(log_q[k].data), 32'(8'hA1 + k));
        check("t2_src", 32'(log_q[k].src), 32'd2);
        check("t2_sop", 32'(log_q[k].sop), 32'(k == 0));
        check("t2_eop", 32'(log_q[k].eop), 32'(k == 3));
        if (k > 0) check("t2_spacing", 32'(log_q[k].cyc - log_q[k-1].cyc), 32'd3);
      end
    end

    // Reset mid-packet on port 2: pointer returns to 0 rather than resuming at 3.
    log_q.delete();
    @(negedge clk);
    for (int b = 0; b < 4; b++) push(2, 8'(8'h50 + b));
    wait_second_beat("t6");
    rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      push(3, 8'(8'h60 + b));
      push(0, 8'(8'h70 + b));
    end
    @(negedge clk);
    log_q.delete();
    rst = 1'b1;
    push(2, 8'h54);
    push(2, 8'h55);
    wait_idle("t6", 300);
    check("t6_count", 32'(log_q.size()), 32'd12);
    if (log_q.size() == 12) begin
      check("t6_first_src", 32'(log_q[0].src), 32'd0);
      check("t6_first_data", 32'(log_q[0].data), 32'h70);
      check("t6_resume_src", 32'(log_q[4].src), 32'd2);
      check("t6_resume_data", 32'(log_q[4].data), 32'h52);
      check("t6_last_src", 32'(log_q[8].src), 32'd3);
    end

    // Backpressure for five clocks on the second byte.
    log_q.delete();
    @(negedge clk);
    for (int b = 0; b < 4; b++) push(0, 8'(8'h80 + b));
    wait_second_beat("t4");
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_data", 32'(bus.out_data), 32'h81);
      check("t4_hold_src", 32'(bus.out_src), 32'd0);
      check("t4_hold_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    wait_idle("t4", 100);
    check("t4_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4)
      for (int k = 0; k < 4; k++) check("t4_data", 32'(log_q[k].data), 32'(8'h80 + k));

    // Starvation: port 1 short by two bytes keeps the grant; port 3 waits.
    log_q.delete();
    @(negedge clk);
    push(1, 8'h90);
    push(1, 8'h91);
    for (int b = 0; b < 4; b++) push(3, 8'(8'hB0 + b));
    repeat (20) @(negedge clk);
    check("t5_busy", 32'(bus.busy), 32'd1);
    check("t5_src", 32'(bus.out_src), 32'd1);
    check("t5_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("t5_partial", 32'(log_q.size()), 32'd2);
    push(1, 8'h92);
    push(1, 8'h93);
    wait_idle("t5", 100);
    check("t5_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        check("t5_p1_data", 32'(log_q[k].data), 32'(8'h90 + k));
        check("t5_p3_src", 32'(log_q[k+4].src), 32'd3);
      end
    end

    // Random traffic and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 7) == 0 && mq[p].size() < 100) push(p, 8'($urandom));
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4000 && (m_active || any_pending()); c++) begin
      @(negedge clk);
      if (m_active && m_need && mq[m_port].size() == 0) push(m_port, 8'($urandom));
    end
    wait_idle("rand", 50);
    repeat (3) @(negedge clk);
    check("final_fifos_empty", 32'(bus.fifo_empty), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
